// File: rtl/rank_order_spike_tx.sv
// Rank-order AER transmitter: captures a sorted pixel-ID frame on start and streams
// one spike event per rank over valid/ready, with an optional idle gap after each event.
module rank_order_spike_tx #(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int INDEX_BITS      = 4,
  parameter int SPIKE_GAP       = 0
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [IMAGE_SIZE-1:0][INDEX_BITS-1:0] sorted_indexes,
  input  logic                                  start,
  input  logic [IMAGE_SIZE_BITS:0]              num_spikes,
  output logic                                  aer_valid,
  input  logic                                  aer_ready,
  output logic [INDEX_BITS-1:0]                 aer_addr,
  output logic [IMAGE_SIZE_BITS:0]              aer_rank,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err_index
);

  localparam int RW = IMAGE_SIZE_BITS + 1;
  localparam int GW = (SPIKE_GAP > 1) ? $clog2(SPIKE_GAP) : 1;
  localparam logic [RW-1:0] SIZE_R = RW'(IMAGE_SIZE);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t                                state, state_n;
  logic [IMAGE_SIZE-1:0][INDEX_BITS-1:0] buffer, buffer_n;
  logic [RW-1:0]                         rank, rank_n, count, count_n;
  logic [GW-1:0]                         gap_cnt, gap_cnt_n;
  logic [INDEX_BITS-1:0]                 entry;
  logic                                  entry_ok, valid_n, err_n;

  always_comb begin
    state_n   = state;
    buffer_n  = buffer;
    rank_n    = rank;
    count_n   = count;
    gap_cnt_n = gap_cnt;
    err_n     = err_index;
    case (state)
      IDLE: if (start) begin
        buffer_n = sorted_indexes;
        rank_n   = '0;
        err_n    = 1'b0;
        count_n  = (num_spikes > SIZE_R) ? SIZE_R : num_spikes;
        state_n  = (count_n == '0) ? DONE : SEND;
      end
      // In SEND, aer_valid low means the current entry is invalid and is skipped
      SEND: if (!aer_valid || aer_ready) begin
        rank_n = rank + 1'b1;
        if (rank_n == count) state_n = DONE;
        else if (aer_valid && SPIKE_GAP > 0) begin
          state_n   = GAP;
          gap_cnt_n = GW'(SPIKE_GAP - 1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = SEND;
        else gap_cnt_n = gap_cnt - 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so the entry for the next rank is looked up here
    entry = '0;
    for (int unsigned i = 0; i < IMAGE_SIZE; i++)
      if (rank_n == RW'(i)) entry = buffer_n[i];
    entry_ok = 32'(entry) < 32'(IMAGE_SIZE);
    valid_n  = (state_n == SEND) && entry_ok;
    if (state_n == SEND && !entry_ok) err_n = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      buffer    <= '0;
      rank      <= '0;
      count     <= '0;
      gap_cnt   <= '0;
      aer_valid <= 1'b0;
      aer_addr  <= '0;
      aer_rank  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_index <= 1'b0;
    end else begin
      state     <= state_n;
      buffer    <= buffer_n;
      rank      <= rank_n;
      count     <= count_n;
      gap_cnt   <= gap_cnt_n;
      aer_valid <= valid_n;
      if (state_n == SEND) aer_addr <= entry;
      aer_rank  <= rank_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      err_index <= err_n;
    end
  end

endmodule

// File: tb/tb_rank_order_spike_tx.sv
// Directed bench for rank_order_spike_tx: one back-to-back instance and one with a 2-cycle gap.
module tb_rank_order_spike_tx;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [4:0][3:0] sorted;
  logic            start0, start1, ready;
  logic [3:0]      num;
  logic            v0, b0, d0, e0, vg, bg, dg, eg;
  logic [3:0]      a0, r0, ag, rg;

  int cmp = 0;
  int bad = 0;
  int expb [5] = '{3, 0, 4, 1, 2};
  int expi [4] = '{3, 4, 1, 2};

  rank_order_spike_tx #(.IMAGE_SIZE(5), .IMAGE_SIZE_BITS(3), .INDEX_BITS(4), .SPIKE_GAP(0)) dut (
    .CLK(CLK), .RST(RST), .sorted_indexes(sorted), .start(start0), .num_spikes(num),
    .aer_valid(v0), .aer_ready(ready), .aer_addr(a0), .aer_rank(r0),
    .busy(b0), .done(d0), .err_index(e0));

  rank_order_spike_tx #(.IMAGE_SIZE(5), .IMAGE_SIZE_BITS(3), .INDEX_BITS(4), .SPIKE_GAP(2)) dut_g (
    .CLK(CLK), .RST(RST), .sorted_indexes(sorted), .start(start1), .num_spikes(num),
    .aer_valid(vg), .aer_ready(ready), .aer_addr(ag), .aer_rank(rg),
    .busy(bg), .done(dg), .err_index(eg));

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_frame(input int a, input int b, input int c, input int d, input int e);
    sorted[0] = 4'(a); sorted[1] = 4'(b); sorted[2] = 4'(c); sorted[3] = 4'(d); sorted[4] = 4'(e);
  endtask

  task automatic test_reset;
    RST = 1'b1; start0 = 1'b0; start1 = 1'b0; ready = 1'b1; num = 4'd5;
    set_frame(3, 0, 4, 1, 2);
    tick; tick;
    cmp++; if ({v0, a0, r0} !== 9'b0) begin bad++; $display("FAIL reset_out: got v=%b a=%0d r=%0d want 0", v0, a0, r0); end
    cmp++; if ({b0, d0, e0} !== 3'b0) begin bad++; $display("FAIL reset_flags: got busy/done/err=%b want 000", {b0, d0, e0}); end
    cmp++; if ({vg, bg, dg, eg} !== 4'b0) begin bad++; $display("FAIL reset_gap_inst: got %b want 0000", {vg, bg, dg, eg}); end
    RST = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    set_frame(3, 0, 4, 1, 2); num = 4'd5; ready = 1'b1;
    start0 = 1'b1; tick; start0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmp++; if ({v0, b0, a0, r0} !== {2'b11, 4'(expb[i]), 4'(i)})
        begin bad++; $display("FAIL basic_ev%0d: got v=%b busy=%b a=%0d r=%0d want v=1 busy=1 a=%0d r=%0d", i, v0, b0, a0, r0, expb[i], i); end
      tick;
    end
    cmp++; if ({d0, v0, e0, b0} !== 4'b1001) begin bad++; $display("FAIL basic_done: got done/valid/err/busy=%b want 1001", {d0, v0, e0, b0}); end
    tick;
    cmp++; if ({d0, b0} !== 2'b00) begin bad++; $display("FAIL basic_idle: got done/busy=%b want 00", {d0, b0}); end
  endtask

  task automatic test_backpressure;
    start0 = 1'b1; tick; start0 = 1'b0;
    cmp++; if ({v0, a0, r0} !== {1'b1, 4'd3, 4'd0}) begin bad++; $display("FAIL bp_ev0: got v=%b a=%0d r=%0d want 1/3/0", v0, a0, r0); end
    tick;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp++; if ({v0, a0, r0} !== {1'b1, 4'd0, 4'd1}) begin bad++; $display("FAIL bp_hold%0d: got v=%b a=%0d r=%0d want 1/0/1", i, v0, a0, r0); end
      tick;
    end
    ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      cmp++; if ({v0, a0, r0} !== {1'b1, 4'(expb[i]), 4'(i)}) begin bad++; $display("FAIL bp_ev%0d: got v=%b a=%0d r=%0d want 1/%0d/%0d", i, v0, a0, r0, expb[i], i); end
      tick;
    end
    cmp++; if ({d0, v0} !== 2'b10) begin bad++; $display("FAIL bp_done: got done/valid=%b want 10", {d0, v0}); end
    tick;
  endtask

  task automatic test_gap;
    num = 4'd3;
    start1 = 1'b1; tick; start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmp++; if ({vg, ag, rg} !== {1'b1, 4'(expb[k]), 4'(k)}) begin bad++; $display("FAIL gap_ev%0d: got v=%b a=%0d r=%0d want 1/%0d/%0d", k, vg, ag, rg, expb[k], k); end
      tick;
      if (k < 2) begin
        for (int j = 0; j < 2; j++) begin
          cmp++; if ({vg, bg, dg} !== 3'b010) begin bad++; $display("FAIL gap_idle%0d_%0d: got valid/busy/done=%b want 010", k, j, {vg, bg, dg}); end
          tick;
        end
      end
    end
    cmp++; if ({dg, vg} !== 2'b10) begin bad++; $display("FAIL gap_done: got done/valid=%b want 10", {dg, vg}); end
    tick;
    cmp++; if (bg !== 1'b0) begin bad++; $display("FAIL gap_idle: got busy=%b want 0", bg); end
  endtask

  task automatic test_edges;
    int cyc, events;
    int got [8];
    num = 4'd0;
    start0 = 1'b1; tick; start0 = 1'b0;
    cmp++; if ({d0, b0, v0} !== 3'b110) begin bad++; $display("FAIL empty_done: got done/busy/valid=%b want 110", {d0, b0, v0}); end
    tick;
    cmp++; if ({d0, b0, v0} !== 3'b000) begin bad++; $display("FAIL empty_idle: got done/busy/valid=%b want 000", {d0, b0, v0}); end
    num = 4'd7;
    start0 = 1'b1; tick; start0 = 1'b0;
    cyc = 0; events = 0;
    while (d0 !== 1'b1 && cyc < 12) begin
      if (v0 === 1'b1) begin
        if (events < 8) got[events] = int'(a0);
        events++;
      end
      tick; cyc++;
    end
    cmp++; if (d0 !== 1'b1) begin bad++; $display("FAIL clamp_timeout: got done=%b want 1 within 12 cycles", d0); end
    cmp++; if (events !== 5) begin bad++; $display("FAIL clamp_count: got %0d events want 5", events); end
    for (int i = 0; i < 5; i++) begin
      cmp++; if (got[i] !== expb[i]) begin bad++; $display("FAIL clamp_ev%0d: got a=%0d want %0d", i, got[i], expb[i]); end
    end
    tick;
  endtask

  task automatic test_invalid;
    int cyc, events;
    int got [8];
    set_frame(3, 6, 4, 1, 2); num = 4'd5; ready = 1'b1;
    start0 = 1'b1; tick; start0 = 1'b0;
    cyc = 0; events = 0;
    while (d0 !== 1'b1 && cyc < 12) begin
      if (v0 === 1'b1) begin
        if (events < 8) got[events] = int'(a0);
        events++;
      end
      if (cyc == 2) begin start0 = 1'b1; set_frame(0, 0, 0, 0, 0); end
      if (cyc == 3) start0 = 1'b0;
      tick; cyc++;
    end
    cmp++; if (cyc !== 5) begin bad++; $display("FAIL inv_done_cycle: got done at cycle %0d want 5", cyc); end
    cmp++; if (events !== 4) begin bad++; $display("FAIL inv_count: got %0d events want 4", events); end
    for (int i = 0; i < 4; i++) begin
      cmp++; if (got[i] !== expi[i]) begin bad++; $display("FAIL inv_ev%0d: got a=%0d want %0d", i, got[i], expi[i]); end
    end
    cmp++; if (e0 !== 1'b1) begin bad++; $display("FAIL inv_err: got err_index=%b want 1", e0); end
    tick; tick;
    cmp++; if ({b0, v0, e0} !== 3'b001) begin bad++; $display("FAIL inv_no_restart: got busy/valid/err=%b want 001", {b0, v0, e0}); end
    set_frame(3, 0, 4, 1, 2);
    start0 = 1'b1; tick; start0 = 1'b0;
    cmp++; if ({e0, v0} !== 2'b01) begin bad++; $display("FAIL inv_err_clear: got err/valid=%b want 01", {e0, v0}); end
    cyc = 0;
    while (d0 !== 1'b1 && cyc < 12) begin tick; cyc++; end
    cmp++; if (d0 !== 1'b1) begin bad++; $display("FAIL inv_frame2_timeout: got done=%b want 1", d0); end
    tick;
  endtask

  task automatic test_reset_mid;
    set_frame(3, 0, 4, 1, 2); num = 4'd5; ready = 1'b1;
    start0 = 1'b1; tick; start0 = 1'b0;
    tick; tick;
    cmp++; if ({v0, a0, r0} !== {1'b1, 4'd4, 4'd2}) begin bad++; $display("FAIL rst_pre: got v=%b a=%0d r=%0d want 1/4/2", v0, a0, r0); end
    #1 RST = 1'b1;
    #1;
    cmp++; if ({v0, b0, d0} !== 3'b000) begin bad++; $display("FAIL rst_async: got valid/busy/done=%b want 000", {v0, b0, d0}); end
    tick;
    RST = 1'b0;
    tick;
    cmp++; if ({v0, b0, d0} !== 3'b000) begin bad++; $display("FAIL rst_idle: got valid/busy/done=%b want 000", {v0, b0, d0}); end
    start0 = 1'b1; tick; start0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmp++; if ({v0, a0, r0} !== {1'b1, 4'(expb[i]), 4'(i)}) begin bad++; $display("FAIL rst_ev%0d: got v=%b a=%0d r=%0d want 1/%0d/%0d", i, v0, a0, r0, expb[i], i); end
      tick;
    end
    cmp++; if ({d0, e0} !== 2'b10) begin bad++; $display("FAIL rst_done: got done/err=%b want 10", {d0, e0}); end
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_gap;
    test_edges;
    test_invalid;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
